// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the divide-sequencer state encoding, the default watchdog limit and the x0 index.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    localparam int unsigned DIV_MAX_CYCLES_DEF = 40;
    localparam logic [4:0]  REG_X0             = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_div_seq.sv
// Divider sequencer: RUN/DIV_BUSY FSM with a watchdog counter and a sticky timeout flag.
// Produces busy (front end frozen), div_release (result capture cycle) and the start pulse.
module pipeline_hazard_ctrl_div_seq
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_MAX_CYCLES = DIV_MAX_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_is_div,
    input  logic div_done,
    output logic busy,
    output logic div_release,
    output logic div_start,
    output logic div_err
);

    localparam int unsigned CNT_W = $clog2(DIV_MAX_CYCLES + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout;

    // Watchdog expiry: the count has reached the limit while still busy
    assign timeout = (cnt_q == CNT_W'(DIV_MAX_CYCLES));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (ex_is_div) state_d = DIV_BUSY;
            DIV_BUSY: if (div_done || timeout) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // FSM outputs; start is gated by reset so it never fires while RST is high
    always_comb begin
        busy        = (state_q == DIV_BUSY);
        div_release = busy && (div_done || timeout);
        div_start   = !rst && (state_q == RUN) && ex_is_div;
        div_err     = err_q;
    end

    // Watchdog counter: counts frozen busy cycles, clears on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == DIV_BUSY && !(div_done || timeout)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Sticky timeout flag; a DONE coinciding with the timeout wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == DIV_BUSY && timeout && !div_done) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch hazards plus
// divider freeze. Optional PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_MAX_CYCLES = DIV_MAX_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic       ID_USES_RS1,
    input  logic       ID_USES_RS2,
    input  logic [4:0] EX_RD,
    input  logic       EX_MEM_READ,
    input  logic       EX_BRANCH_SELECT,
    input  logic       EX_IS_DIV,
    input  logic       DIV_DONE,
    output logic       PC_WRITE,
    output logic       IF_ID_WRITE,
    output logic       IF_ID_FLUSH,
    output logic       ID_EX_WRITE,
    output logic       ID_EX_FLUSH,
    output logic       EX_MEM_FLUSH,
    output logic       DIV_START,
    output logic       DIV_ERR
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
`endif
);

    logic busy;
    logic div_release;
    logic load_use;

    pipeline_hazard_ctrl_div_seq #(
        .DIV_MAX_CYCLES(DIV_MAX_CYCLES)
    ) u_div_seq (
        .clk        (CLK),
        .rst        (RST),
        .ex_is_div  (EX_IS_DIV),
        .div_done   (DIV_DONE),
        .busy       (busy),
        .div_release(div_release),
        .div_start  (DIV_START),
        .div_err    (DIV_ERR)
    );

    // Load-use: a load in EX writes a register the ID instruction reads (x0 never hazards)
    always_comb begin
        load_use = EX_MEM_READ && (EX_RD != REG_X0) &&
                   ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                    (ID_USES_RS2 && (ID_RS2 == EX_RD)));
    end

    // Output muxing: reset, divider freeze, then divide start > branch > load-use
    always_comb begin
        PC_WRITE     = 1'b1;
        IF_ID_WRITE  = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_WRITE  = 1'b1;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_FLUSH = 1'b0;
        if (RST) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            ID_EX_WRITE  = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
        end else if (busy) begin
            // Release cycle keeps the defaults so EX_MEM captures the result
            if (!div_release) begin
                PC_WRITE     = 1'b0;
                IF_ID_WRITE  = 1'b0;
                ID_EX_WRITE  = 1'b0;
                EX_MEM_FLUSH = 1'b1;
            end
        end else if (EX_IS_DIV) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            ID_EX_WRITE  = 1'b0;
            EX_MEM_FLUSH = 1'b1;
        end else if (EX_BRANCH_SELECT) begin
            // ID holds a wrong-path instruction, so its load-use hazard is moot
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else if (load_use) begin
            PC_WRITE    = 1'b0;
            IF_ID_WRITE = 1'b0;
            ID_EX_FLUSH = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating performance counters, cleared by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!PC_WRITE && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (IF_ID_FLUSH && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table-driven RUN vectors plus
// hand-written divide, watchdog and reset sequences. Two DUTs share stimulus:
// dut_a uses the default watchdog limit, dut_b a limit of 8.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_select, ex_is_div, div_done;

    logic pc_w_a, ifid_w_a, ifid_f_a, idex_w_a, idex_f_a, exmem_f_a, start_a, err_a;
    logic pc_w_b, ifid_w_b, ifid_f_b, idex_w_b, idex_f_b, exmem_f_b, start_b, err_b;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_WRITE, ID_EX_FLUSH, EX_MEM_FLUSH, DIV_START}
    localparam logic [6:0] O_IDLE   = 7'b1101000;
    localparam logic [6:0] O_LU     = 7'b0001100;
    localparam logic [6:0] O_BR     = 7'b1111100;
    localparam logic [6:0] O_START  = 7'b0000011;
    localparam logic [6:0] O_FROZEN = 7'b0000010;
    localparam logic [6:0] O_RST    = 7'b0010110;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DIV_MAX_CYCLES(40)) dut_a (
        .CLK(clk), .RST(rst), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2), .EX_RD(ex_rd),
        .EX_MEM_READ(ex_mem_read), .EX_BRANCH_SELECT(ex_branch_select),
        .EX_IS_DIV(ex_is_div), .DIV_DONE(div_done),
        .PC_WRITE(pc_w_a), .IF_ID_WRITE(ifid_w_a), .IF_ID_FLUSH(ifid_f_a),
        .ID_EX_WRITE(idex_w_a), .ID_EX_FLUSH(idex_f_a), .EX_MEM_FLUSH(exmem_f_a),
        .DIV_START(start_a), .DIV_ERR(err_a)
`ifdef PIPE_CTRL_PERF_EN
        , .STALL_CNT(stall_a), .FLUSH_CNT(flush_a)
`endif
    );

    pipeline_hazard_ctrl #(.DIV_MAX_CYCLES(8)) dut_b (
        .CLK(clk), .RST(rst), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2), .EX_RD(ex_rd),
        .EX_MEM_READ(ex_mem_read), .EX_BRANCH_SELECT(ex_branch_select),
        .EX_IS_DIV(ex_is_div), .DIV_DONE(div_done),
        .PC_WRITE(pc_w_b), .IF_ID_WRITE(ifid_w_b), .IF_ID_FLUSH(ifid_f_b),
        .ID_EX_WRITE(idex_w_b), .ID_EX_FLUSH(idex_f_b), .EX_MEM_FLUSH(exmem_f_b),
        .DIV_START(start_b), .DIV_ERR(err_b)
`ifdef PIPE_CTRL_PERF_EN
        , .STALL_CNT(stall_b), .FLUSH_CNT(flush_b)
`endif
    );

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] outs_a();
        return 32'({pc_w_a, ifid_w_a, ifid_f_a, idex_w_a, idex_f_a, exmem_f_a, start_a});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({pc_w_b, ifid_w_b, ifid_f_b, idex_w_b, idex_f_b, exmem_f_b, start_b});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic clr_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_select = 1'b0; ex_is_div = 1'b0; div_done = 1'b0;
    endtask

    // Advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-edge reset, released mid-cycle
    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic load_use_in();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"idle",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_IDLE};
        vecs[1] = '{"lu_rs1",        5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, O_LU};
        vecs[2] = '{"lu_cleared",    5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, O_IDLE};
        vecs[3] = '{"lu_x0",         5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, O_IDLE};
        vecs[4] = '{"lu_rs2",        5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, O_LU};
        vecs[5] = '{"rs2_unused",    5'd1, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, O_IDLE};
        vecs[6] = '{"not_load",      5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, O_IDLE};
        vecs[7] = '{"br_over_lu",    5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, O_BR};
        vecs[8] = '{"branch",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, O_BR};
        vecs[9] = '{"rs1_mismatch",  5'd6, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, O_IDLE};

        // Reset state, with a divide request present to prove DIV_START is held low
        rst = 1'b1;
        clr_in();
        ex_is_div = 1'b1;
        load_use_in();
        #2;
        check("reset_outs_a", outs_a(), 32'(O_RST));
        check("reset_outs_b", outs_b(), 32'(O_RST));
        check("reset_err_a", 32'(err_a), 32'd0);
        tick();
        check("reset_hold_a", outs_a(), 32'(O_RST));
        do_reset();

        // Combinational RUN vectors
        for (int i = 0; i < 10; i++) begin
            tick();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr; ex_branch_select = vecs[i].br;
            #1;
            check(vecs[i].name, outs_a(), 32'(vecs[i].exp));
        end

        // Divide: start cycle, 33 frozen busy cycles, DONE on the 34th busy cycle
        tick();
        clr_in();
        ex_is_div = 1'b1;
        #1;
        check("div_start", outs_a(), 32'(O_START));
        for (int k = 1; k <= 33; k++) begin
            tick();
            // Hazards presented mid-divide must be ignored
            ex_branch_select = (k == 10);
            if (k == 11) load_use_in();
            else begin
                ex_mem_read = 1'b0; id_uses_rs1 = 1'b0;
            end
            #1;
            check("div_frozen", outs_a(), 32'(O_FROZEN));
        end
        tick();
        ex_branch_select = 1'b0; ex_mem_read = 1'b0;
        div_done = 1'b1;
        #1;
        check("div_release", outs_a(), 32'(O_IDLE));
        tick();
        div_done = 1'b0;
        ex_is_div = 1'b0;
        #1;
        check("div_back_run", outs_a(), 32'(O_IDLE));
        check("div_no_err", 32'(err_a), 32'd0);
        tick();
        load_use_in();
        #1;
        check("post_div_lu", outs_a(), 32'(O_LU));
        tick();
        clr_in();
        div_done = 1'b1;
        #1;
        check("done_in_run", outs_a(), 32'(O_IDLE));

        // Watchdog on dut_b: 8 frozen busy cycles then forced release
        do_reset();
        tick();
        ex_is_div = 1'b1;
        #1;
        check("wd_start", outs_b(), 32'(O_START));
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            check("wd_frozen", outs_b(), 32'(O_FROZEN));
        end
        tick();
        #1;
        check("wd_release", outs_b(), 32'(O_IDLE));
        check("wd_err_pre", 32'(err_b), 32'd0);
        tick();
        ex_is_div = 1'b0;
        #1;
        check("wd_err_set", 32'(err_b), 32'd1);
        tick();
        ex_is_div = 1'b1;
        #1;
        check("wd_start2", outs_b(), 32'(O_START));
        tick();
        #1;
        check("wd_frozen2", outs_b(), 32'(O_FROZEN));
        tick();
        div_done = 1'b1;
        #1;
        check("wd_release2", outs_b(), 32'(O_IDLE));
        tick();
        div_done = 1'b0;
        ex_is_div = 1'b0;
        #1;
        check("wd_err_sticky", 32'(err_b), 32'd1);

        // DONE on the timeout cycle is a normal completion
        do_reset();
        check("wd_err_cleared", 32'(err_b), 32'd0);
        tick();
        ex_is_div = 1'b1;
        for (int k = 1; k <= 8; k++) tick();
        tick();
        div_done = 1'b1;
        #1;
        check("wd_done_at_limit", outs_b(), 32'(O_IDLE));
        tick();
        div_done = 1'b0;
        ex_is_div = 1'b0;
        #1;
        check("wd_done_no_err", 32'(err_b), 32'd0);

        // Asynchronous reset three cycles into DIV_BUSY
        do_reset();
        tick();
        ex_is_div = 1'b1;
        #1;
        check("mid_start", outs_a(), 32'(O_START));
        for (int k = 1; k <= 3; k++) begin
            tick();
            #1;
            check("mid_frozen", outs_a(), 32'(O_FROZEN));
        end
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_outs", outs_a(), 32'(O_RST));
        #1;
        rst = 1'b0;
        #1;
        // Still requesting a divide: a fresh start pulse proves the FSM is back in RUN
        check("mid_rst_run", outs_a(), 32'(O_START));
        check("mid_rst_err", 32'(err_a), 32'd0);

`ifdef PIPE_CTRL_PERF_EN
        // 1 load-use stall, 1 branch, 1 divide with 5 frozen busy cycles
        do_reset();
        tick();
        load_use_in();
        tick();
        clr_in();
        tick();
        ex_branch_select = 1'b1;
        tick();
        clr_in();
        ex_is_div = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        tick();
        div_done = 1'b1;
        tick();
        clr_in();
        #1;
        check("perf_stall_cnt", stall_a, 32'd7);
        check("perf_flush_cnt", flush_a, 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
